// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported synchronous memory between instruction fetch (F)
// and data load/store (D); D has priority, bounded by a starvation limit for F.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner_d;
  logic       cap_we;
  logic       d_win;
  logic       f_win;

  // Winner selection; grants are suppressed while reset is asserted
  always_comb begin
    d_win = 1'b0;
    f_win = 1'b0;
    if (state == IDLE && !reset) begin
      d_win = d_req && !(f_req && (starve_cnt == 4'(STARVE_MAX)));
      f_win = f_req && !d_win;
    end else begin
      d_win = 1'b0;
      f_win = 1'b0;
    end
  end

  assign d_gnt = d_win;
  assign f_gnt = f_win;
  assign busy  = (state != IDLE);

  // Access sequencer: capture on grant, strobe memory, count latency, return data
  always_ff @(posedge clk1) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
      owner_d    <= 1'b0;
      cap_we     <= 1'b0;
      f_rvalid   <= 1'b0;
      f_rdata    <= 32'd0;
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            state     <= ISSUE;
            owner_d   <= 1'b1;
            cap_we    <= d_we;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!f_req) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= starve_cnt;
            end
          end else if (f_win) begin
            state      <= ISSUE;
            owner_d    <= 1'b0;
            cap_we     <= 1'b0;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= f_addr;
            mem_wdata  <= 32'd0;
            starve_cnt <= 4'd0;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          lat_cnt <= 3'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          // Count of 1 marks the cycle in which mem_rdata is valid
          if (lat_cnt == 3'd1) begin
            state <= IDLE;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= cap_we ? 32'd0 : mem_rdata;
            end else begin
              f_rvalid <= 1'b1;
              f_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a timestamp-based
// transaction model with its own reference memory image.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 3;

  logic          clk1 = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt, f_rvalid;
  logic [31:0]   f_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = 32'd0;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk1(clk1), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  int n_chk = 0;
  int n_fail = 0;

  // memory behind the DUT, and the model's own view of memory contents
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int rd_due = -1;
  logic [AW-1:0] rd_addr = '0;

  // model state: everything is expressed as cycle timestamps
  int cyc = 0;
  int free_at = 0;
  int gcyc = -10;
  int sc = 0;
  int exp_en_cyc = -1;
  int exp_rv_cyc = -1;
  logic exp_rv_d = 1'b0;
  logic [31:0] exp_rv_data = 32'd0;
  logic [31:0] exp_f_rdata = 32'd0;
  logic [31:0] exp_d_rdata = 32'd0;
  logic [AW-1:0] exp_addr = '0;
  logic exp_we = 1'b0;
  logic [31:0] exp_wdata = 32'd0;
  logic after_rst = 1'b0;
  bit gq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // one clock cycle: drive, compare against model, then advance the model
  task automatic step(input logic rst, input logic fr, input logic [AW-1:0] fa,
                      input logic dr, input logic dwe, input logic [AW-1:0] da,
                      input logic [31:0] dwd);
    logic dw, fw, ev, rvn;
    @(posedge clk1);
    cyc++;
    #1;
    reset = rst; f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    mem_rdata = (cyc == rd_due) ? mem[rd_addr] : $urandom;
    #3;
    dw = !rst && (cyc >= free_at) && dr && !(fr && sc == STARVE_MAX);
    fw = !rst && (cyc >= free_at) && fr && !dw;
    check_eq("d_gnt", 32'(d_gnt), 32'(dw));
    check_eq("f_gnt", 32'(f_gnt), 32'(fw));
    check_eq("busy", 32'(busy), 32'((cyc > gcyc) && (cyc < free_at)));
    ev = (cyc == exp_en_cyc);
    check_eq("mem_en", 32'(mem_en), 32'(ev));
    if (ev) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check_eq("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
    end else begin
      check_eq("mem_we_idle", 32'(mem_we), 32'd0);
    end
    rvn = (cyc == exp_rv_cyc);
    check_eq("f_rvalid", 32'(f_rvalid), 32'(rvn && !exp_rv_d));
    check_eq("d_rvalid", 32'(d_rvalid), 32'(rvn && exp_rv_d));
    if (rvn && exp_rv_d) exp_d_rdata = exp_rv_data;
    if (rvn && !exp_rv_d) exp_f_rdata = exp_rv_data;
    check_eq("f_rdata", f_rdata, exp_f_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    if (after_rst) begin
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    end
    // memory reacts to the strobe it sees
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
      else begin rd_due = cyc + MEM_LAT; rd_addr = mem_addr; end
    end
    if (dw || fw) begin
      gcyc = cyc;
      free_at = cyc + MEM_LAT + 2;
      exp_en_cyc = cyc + 1;
      exp_rv_cyc = cyc + MEM_LAT + 2;
      exp_rv_d = dw;
      gq.push_back(dw);
      if (dw) begin
        exp_addr = da; exp_we = dwe; exp_wdata = dwd;
        if (dwe) begin ref_mem[da] = dwd; exp_rv_data = 32'd0; end
        else exp_rv_data = ref_mem[da];
        sc = fr ? ((sc < STARVE_MAX) ? sc + 1 : STARVE_MAX) : 0;
      end else begin
        exp_addr = fa; exp_we = 1'b0;
        exp_rv_data = ref_mem[fa];
        sc = 0;
      end
    end
    if (rst) begin
      free_at = cyc + 1; gcyc = cyc; sc = 0;
      if (exp_en_cyc > cyc) exp_en_cyc = -1;
      if (exp_rv_cyc > cyc) exp_rv_cyc = -1;
      exp_f_rdata = 32'd0; exp_d_rdata = 32'd0;
    end
    after_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  initial begin
    logic [7:0] order;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
      ref_mem[i] = mem[i];
    end
    mem[10'h010] = 32'hDEADBEEF;
    ref_mem[10'h010] = 32'hDEADBEEF;
    repeat (3) @(posedge clk1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0);

    // fetch read
    step(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, '0, 32'd0);
    idle(6);
    check_eq("fetch_data", f_rdata, 32'hDEADBEEF);

    // store then load the same word
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h020, 32'h12345678);
    idle(4);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'h020, 32'd0);
    idle(4);
    check_eq("load_data", d_rdata, 32'h12345678);

    // contention: both requests held continuously
    gq.delete();
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'b1, 10'($urandom_range(15)), 1'b1, 1'b0, 10'($urandom_range(15)), 32'd0);
    idle(5);
    check_eq("grant_count", 32'(gq.size()), 32'd10);
    for (int i = 0; i < 8; i++) order[7-i] = (gq.size() > i) ? gq[i] : 1'b0;
    check_eq("grant_order", 32'(order), 32'(8'b1110_1110));

    // D only: five loads, starvation counter never engages
    gq.delete();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'($urandom_range(31)), 32'd0);
    idle(5);
    check_eq("d_only_count", 32'(gq.size()), 32'd5);

    // reset in WAIT, then immediate re-grant
    step(1'b0, 1'b1, 10'h010, 1'b0, 1'b0, '0, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0);
    step(1'b0, 1'b1, 10'h011, 1'b0, 1'b0, '0, 32'd0);
    idle(6);
    // reset in ISSUE after a store strobe
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 10'h005, 32'hCAFEF00D);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 32'd0);
    idle(3);

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++)
      step(($urandom_range(99) == 0), ($urandom_range(3) != 0), 10'($urandom_range(15)),
           ($urandom_range(3) != 0), ($urandom_range(2) == 0), 10'($urandom_range(15)), $urandom);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
